image_resize_frame_ctrl: RTL

Frame-level sequencer for the pixel-decimating image resizer. It accepts a start command with a frame configuration, validates it and holds it stable on the resizer's configuration inputs for the whole frame. It gates the input stream so exactly width*depth pixels reach the resizer, counts the decimated output pixels, and reports done, error and frame statistics to software-facing registers.

---
 rtl/image_resize_pkg.sv | 23 ++
 rtl/image_resize_cfg_check.sv | 48 ++++
 rtl/image_resize_frame_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/image_resize_pkg.sv
// Shared definitions for the image resizer frame controller.
//   state_t          : frame sequencer states
//   ERR_*            : codes reported on o_error
//   DEF_CNT_W        : default pixel counter width
//   DEF_FRAME_CNT_W  : default completed-frame counter width
package image_resize_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CFG   = 2'd1;
  localparam logic [1:0] ERR_ABORT = 2'd2;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_FRAME_CNT_W = 16;

endpackage

// File: rtl/image_resize_cfg_check.sv
// Registered frame-size product and configuration validity check.
// The product and verdict are captured on the same edge that latches the
// frame configuration, so both are stable throughout the CHECK cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   load                : capture a new configuration
//   width, depth        : requested frame size
//   width_scale,
//   depth_scale         : decimation factors
//   total               : width*depth (valid when cfg_ok)
//   cfg_ok              : configuration is usable
module image_resize_cfg_check
  import image_resize_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      width,
  input  logic [31:0]      depth,
  input  logic [31:0]      width_scale,
  input  logic [31:0]      depth_scale,
  output logic [CNT_W-1:0] total,
  output logic             cfg_ok
);

  logic [63:0] prod;
  logic        too_big;
  logic        bad;

  assign prod    = {32'd0, width} * {32'd0, depth};
  // Any bit at or above CNT_W means the frame cannot be counted.
  assign too_big = (prod >> CNT_W) != 64'd0;
  assign bad     = (width == 32'd0) || (depth == 32'd0) ||
                   (width_scale == 32'd0) || (depth_scale == 32'd0) ||
                   (width_scale > width) || (depth_scale > depth) || too_big;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total  <= '0;
      cfg_ok <= 1'b0;
    end else if (load) begin
      total  <= prod[CNT_W-1:0];
      cfg_ok <= ~bad;
    end
  end

endmodule

// File: rtl/image_resize_frame_ctrl.sv
// Frame-level sequencer for the pixel-decimating image resizer.
// Latches and validates a frame configuration on cfg_start, passes exactly
// width*depth input beats to the resizer, counts decimated output pixels and
// reports done / error / frame statistics.
//   axi_aclk, axi_reset            : clock, asynchronous active-high reset
//   cfg_*                          : requested configuration, start/abort pulses
//   s_data_valid / s_data_ready    : upstream pixel handshake
//   dp_data_valid / dp_data_ready  : pixel handshake toward the resizer
//   dp_out_valid                   : resizer output strobe (counted only)
//   dp_image_*, dp_*_scale         : latched configuration driven to the resizer
//   o_busy, o_done, o_error        : status
//   o_out_pixel_count, o_frame_count : statistics
// Handshake: a beat transfers in a cycle where valid and ready are both high;
// valid does not depend on ready. Outside RUN both directions are held low.
module image_resize_frame_ctrl
  import image_resize_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int FRAME_CNT_W = DEF_FRAME_CNT_W
) (
  input  logic                   axi_aclk,
  input  logic                   axi_reset,
  input  logic [31:0]            cfg_image_width,
  input  logic [31:0]            cfg_image_depth,
  input  logic [31:0]            cfg_width_scale,
  input  logic [31:0]            cfg_depth_scale,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic                   s_data_valid,
  output logic                   s_data_ready,
  output logic                   dp_data_valid,
  input  logic                   dp_data_ready,
  input  logic                   dp_out_valid,
  output logic [31:0]            dp_image_width,
  output logic [31:0]            dp_image_depth,
  output logic [31:0]            dp_width_scale,
  output logic [31:0]            dp_depth_scale,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [1:0]             o_error,
  output logic [CNT_W-1:0]       o_out_pixel_count,
  output logic [FRAME_CNT_W-1:0] o_frame_count
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] total;
  logic             cfg_ok;
  logic             accept;
  logic             beat;
  logic             last_beat;

  // Abort has priority over a simultaneous start.
  assign accept    = (state == ST_IDLE) && cfg_start && !cfg_abort;
  assign beat      = (state == ST_RUN) && s_data_valid && dp_data_ready;
  assign last_beat = beat && ((in_cnt + CNT_W'(1)) == total);

  image_resize_cfg_check #(.CNT_W(CNT_W)) u_cfg_check (
    .clk         (axi_aclk),
    .rst         (axi_reset),
    .load        (accept),
    .width       (cfg_image_width),
    .depth       (cfg_image_depth),
    .width_scale (cfg_width_scale),
    .depth_scale (cfg_depth_scale),
    .total       (total),
    .cfg_ok      (cfg_ok)
  );

  // State register
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) state <= ST_IDLE;
    else           state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_CHECK;
      ST_CHECK: begin
        if (cfg_abort)   next_state = ST_IDLE;
        else if (cfg_ok) next_state = ST_RUN;
        else             next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (cfg_abort)      next_state = ST_IDLE;
        else if (last_beat) next_state = ST_DRAIN;
      end
      ST_DRAIN: next_state = cfg_abort ? ST_IDLE : ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_data_ready  = (state == ST_RUN) && dp_data_ready;
    dp_data_valid = (state == ST_RUN) && s_data_valid;
    o_busy        = (state != ST_IDLE);
    o_done        = (state == ST_DONE);
  end

  // Configuration, counters and error register
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      dp_image_width    <= '0;
      dp_image_depth    <= '0;
      dp_width_scale    <= '0;
      dp_depth_scale    <= '0;
      in_cnt            <= '0;
      o_error           <= ERR_NONE;
      o_out_pixel_count <= '0;
      o_frame_count     <= '0;
    end else begin
      if (accept) begin
        dp_image_width <= cfg_image_width;
        dp_image_depth <= cfg_image_depth;
        dp_width_scale <= cfg_width_scale;
        dp_depth_scale <= cfg_depth_scale;
        in_cnt         <= '0;
      end
      if (beat) in_cnt <= in_cnt + CNT_W'(1);
      case (state)
        ST_CHECK: begin
          if (cfg_abort) begin
            o_error <= ERR_ABORT;
          end else if (cfg_ok) begin
            o_error           <= ERR_NONE;
            o_out_pixel_count <= '0;
          end else begin
            o_error <= ERR_CFG;
          end
        end
        // DRAIN still counts: resizer output lags the last accepted pixel.
        ST_RUN, ST_DRAIN: begin
          if (cfg_abort)    o_error <= ERR_ABORT;
          if (dp_out_valid) o_out_pixel_count <= o_out_pixel_count + CNT_W'(1);
        end
        ST_DONE: o_frame_count <= o_frame_count + FRAME_CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
